// File: rtl/des_io_pkg.sv
// Shared types and constants for the serial I/O sequencer in front of the 3DES core.
package des_io_pkg;

    // Native DES/3DES block width.
    localparam int DES_BLK_W = 64;

    // Output serialiser states.
    typedef enum logic [0:0] {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

endpackage : des_io_pkg

// File: rtl/flex_counter.sv
// Up-counter that runs 0 .. rollover_val-1 and wraps to 0. Used for the RX and TX bit counters.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] last_val;

    assign last_val = rollover_val - NUM_CNT_BITS'(1);

    // Count enabled events; clear has priority and covers reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= (count_out == last_val) ? '0 : count_out + NUM_CNT_BITS'(1);
        end
    end

endmodule : flex_counter

// File: rtl/des_io_sequencer.sv
// Serial block I/O around the 3DES core: deserialises input blocks into a one-deep hold buffer,
// hands them to the core, captures the core result and shifts it back out MSB-first.
module des_io_sequencer
    import des_io_pkg::*;
#(
    parameter int BLK_W = DES_BLK_W,
    parameter int CNT_W = 7
) (
    input  logic             sclk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             blk_valid,
    output logic [BLK_W-1:0] blk_data,
    input  logic             blk_ready,
    input  logic             res_valid,
    input  logic [BLK_W-1:0] res_data,
    output logic             res_ready,
    output logic             sout_valid,
    output logic             sout_data,
    input  logic             sout_ready,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ROLL_VAL = CNT_W'(BLK_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BLK_W - 1);

    // Reset and soft abort have identical effect on the datapath.
    logic             flush;
    logic [CNT_W-1:0] rx_cnt;
    logic [CNT_W-1:0] tx_cnt;
    // Only the first BLK_W-1 bits are ever stored here: the final bit goes straight into hold.
    logic [BLK_W-2:0] rx_shift;
    logic [BLK_W-1:0] rx_block;
    logic             rx_done;
    logic             hold_valid;
    logic [BLK_W-1:0] hold_data;
    tx_state_t        tx_state;
    logic [BLK_W-1:0] tx_shift;
    logic             tx_accept;

    assign flush    = clear | ~n_rst;
    assign rx_block = {rx_shift, sin_data};
    assign rx_done  = sin_valid & (rx_cnt == LAST_BIT);
    assign tx_accept = (tx_state == TX_SHIFT) & sout_ready;

    flex_counter #(.NUM_CNT_BITS(CNT_W)) u_rx_cnt (
        .clk          (sclk),
        .clear        (flush),
        .count_enable (sin_valid),
        .rollover_val (ROLL_VAL),
        .count_out    (rx_cnt)
    );

    flex_counter #(.NUM_CNT_BITS(CNT_W)) u_tx_cnt (
        .clk          (sclk),
        .clear        (flush),
        .count_enable (tx_accept),
        .rollover_val (ROLL_VAL),
        .count_out    (tx_cnt)
    );

    // Deserialiser: shift each strobed bit in at the LSB end.
    always_ff @(posedge sclk) begin
        if (flush) begin
            rx_shift <= '0;
        end else if (sin_valid) begin
            rx_shift <= (BLK_W-1)'(rx_block);
        end
    end

    // Hold buffer and overrun policy: a completed block loads if hold is free or being
    // accepted this same cycle; otherwise it is dropped and overrun sticks.
    always_ff @(posedge sclk) begin
        // NOTE: the hold data is reset as well as its valid flag because blk_data must read 0 after reset.
        if (flush) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            overrun    <= 1'b0;
        end else if (rx_done && (!hold_valid || blk_ready)) begin
            hold_valid <= 1'b1;
            hold_data  <= rx_block;
        end else begin
            if (hold_valid && blk_ready) begin
                hold_valid <= 1'b0;
            end
            if (rx_done) begin
                overrun <= 1'b1;
            end
        end
    end

    // Serialiser FSM: capture a result when idle, then emit BLK_W bits MSB-first.
    always_ff @(posedge sclk) begin
        if (flush) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (res_valid) begin
                        tx_shift <= res_data;
                        tx_state <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (sout_ready) begin
                        tx_shift <= {tx_shift[BLK_W-2:0], 1'b0};
                        if (tx_cnt == LAST_BIT) begin
                            tx_state <= TX_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign blk_valid  = hold_valid;
    assign blk_data   = hold_data;
    assign res_ready  = (tx_state == TX_IDLE);
    assign sout_valid = (tx_state == TX_SHIFT);
    assign sout_data  = (tx_state == TX_SHIFT) & tx_shift[BLK_W-1];
    assign busy       = (rx_cnt != '0) | hold_valid | (tx_state != TX_IDLE);

endmodule : des_io_sequencer

// File: tb/tb_des_io_sequencer.sv
// Directed bench for des_io_sequencer with a queue-based reference model checked every cycle.
module tb_des_io_sequencer;

    localparam int BLK_W = 64;

    logic             sclk = 1'b0;
    logic             n_rst = 1'b0;
    logic             clear = 1'b0;
    logic             sin_valid = 1'b0;
    logic             sin_data = 1'b0;
    logic             blk_valid;
    logic [BLK_W-1:0] blk_data;
    logic             blk_ready = 1'b0;
    logic             res_valid = 1'b0;
    logic [BLK_W-1:0] res_data = '0;
    logic             res_ready;
    logic             sout_valid;
    logic             sout_data;
    logic             sout_ready = 1'b0;
    logic             overrun;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference model state
    int               m_rx_cnt = 0;
    logic [BLK_W-1:0] m_rx_val = '0;
    bit               m_hold_v = 1'b0;
    logic [BLK_W-1:0] m_hold_d = '0;
    bit               m_ovr    = 1'b0;
    bit               m_txq[$];
    bit               out_log[$];

    des_io_sequencer #(.BLK_W(BLK_W), .CNT_W(7)) dut (
        .sclk       (sclk),
        .n_rst      (n_rst),
        .clear      (clear),
        .sin_valid  (sin_valid),
        .sin_data   (sin_data),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .blk_ready  (blk_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .sout_valid (sout_valid),
        .sout_data  (sout_data),
        .sout_ready (sout_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] log_word();
        logic [63:0] w = '0;
        foreach (out_log[i]) w = {w[62:0], out_log[i]};
        return w;
    endfunction

    // Reference model: block-level view of RX, hold buffer and TX bit queue.
    initial begin : model
        bit done;
        bit was_v;
        forever begin
            @(posedge sclk);
            if (sout_valid && sout_ready) out_log.push_back(sout_data);
            if (!n_rst || clear) begin
                m_rx_cnt = 0;
                m_rx_val = '0;
                m_hold_v = 1'b0;
                m_hold_d = '0;
                m_ovr    = 1'b0;
                m_txq.delete();
            end else begin
                done  = sin_valid && (m_rx_cnt == BLK_W - 1);
                was_v = m_hold_v;
                if (sin_valid) begin
                    m_rx_val = {m_rx_val[BLK_W-2:0], sin_data};
                    m_rx_cnt = (m_rx_cnt + 1) % BLK_W;
                end
                if (was_v && blk_ready) m_hold_v = 1'b0;
                if (done) begin
                    if (!was_v || blk_ready) begin
                        m_hold_v = 1'b1;
                        m_hold_d = m_rx_val;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
                if (m_txq.size() != 0) begin
                    if (sout_ready) void'(m_txq.pop_front());
                end else if (res_valid) begin
                    for (int i = BLK_W - 1; i >= 0; i--) m_txq.push_back(res_data[i]);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin : compare
        forever begin
            @(negedge sclk);
            if (cmp_en) begin
                check("blk_valid", 64'(blk_valid), 64'(m_hold_v));
                if (m_hold_v) check("blk_data", blk_data, m_hold_d);
                check("overrun", 64'(overrun), 64'(m_ovr));
                check("res_ready", 64'(res_ready), 64'(m_txq.size() == 0));
                check("sout_valid", 64'(sout_valid), 64'(m_txq.size() != 0));
                if (m_txq.size() != 0) check("sout_data", 64'(sout_data), 64'(m_txq[0]));
                check("busy", 64'(busy), 64'((m_rx_cnt != 0) || m_hold_v || (m_txq.size() != 0)));
            end
        end
    end

    task automatic send_block(input logic [63:0] d, input bit ready_on_last);
        for (int i = BLK_W - 1; i >= 0; i--) begin
            sin_valid = 1'b1;
            sin_data  = d[i];
            if (ready_on_last) blk_ready = (i == 0);
            @(negedge sclk);
        end
        sin_valid = 1'b0;
        sin_data  = 1'b0;
        if (ready_on_last) blk_ready = 1'b0;
    endtask

    // Capture one result and drain it, optionally with a random stall pattern.
    task automatic run_tx(input logic [63:0] r, input bit random_stall, output int low_cycles);
        int n;
        out_log.delete();
        sout_ready = 1'b1;
        res_data   = r;
        res_valid  = 1'b1;
        @(negedge sclk);
        res_valid  = 1'b0;
        check("tx_first_valid", 64'(sout_valid), 64'd1);
        check("tx_first_bit", 64'(sout_data), 64'(r[63]));
        low_cycles = 0;
        n = 0;
        while (res_ready == 1'b0 && n < 2000) begin
            if (random_stall) sout_ready = 1'($urandom_range(0, 1));
            low_cycles++;
            n++;
            @(negedge sclk);
        end
        sout_ready = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int low;
        logic [63:0] junk;

        @(negedge sclk);
        @(negedge sclk);
        check("rst_blk_valid", 64'(blk_valid), 64'd0);
        check("rst_blk_data", blk_data, 64'd0);
        check("rst_res_ready", 64'(res_ready), 64'd1);
        check("rst_sout_valid", 64'(sout_valid), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        n_rst  = 1'b1;
        cmp_en = 1'b1;
        @(negedge sclk);

        // 1: single block, core ready
        blk_ready = 1'b1;
        send_block(64'h0123456789ABCDEF, 1'b0);
        check("c1_blk_valid", 64'(blk_valid), 64'd1);
        check("c1_blk_data", blk_data, 64'h0123456789ABCDEF);
        @(negedge sclk);
        check("c1_blk_valid_drop", 64'(blk_valid), 64'd0);
        check("c1_overrun", 64'(overrun), 64'd0);

        // 2: core stalled, second block overruns; clear recovers
        blk_ready = 1'b0;
        send_block(64'hA5A5_0000_FFFF_1234, 1'b0);
        check("c2_hold_a", blk_data, 64'hA5A5_0000_FFFF_1234);
        check("c2_no_ovr_yet", 64'(overrun), 64'd0);
        send_block(64'h0F0F_1111_2222_3333, 1'b0);
        check("c2_overrun", 64'(overrun), 64'd1);
        check("c2_keeps_a", blk_data, 64'hA5A5_0000_FFFF_1234);
        clear = 1'b1;
        @(negedge sclk);
        clear = 1'b0;
        check("c2_clr_overrun", 64'(overrun), 64'd0);
        check("c2_clr_blk_valid", 64'(blk_valid), 64'd0);
        check("c2_clr_busy", 64'(busy), 64'd0);

        // 3: completion coincides with handshake of the previous block
        send_block(64'hCAFE_BABE_DEAD_BEEF, 1'b0);
        send_block(64'h1357_9BDF_2468_ACE0, 1'b1);
        check("c3_blk_valid", 64'(blk_valid), 64'd1);
        check("c3_blk_data", blk_data, 64'h1357_9BDF_2468_ACE0);
        check("c3_overrun", 64'(overrun), 64'd0);
        blk_ready = 1'b1;
        @(negedge sclk);
        blk_ready = 1'b0;

        // 4: result serialised with no stalls
        run_tx(64'h85E813540F0AB405, 1'b0, low);
        check("c4_res_ready_low", 64'(low), 64'd64);
        check("c4_bit_count", 64'(out_log.size()), 64'd64);
        check("c4_stream", log_word(), 64'h85E813540F0AB405);

        // 5: random output stalls while an input block arrives concurrently
        fork
            begin
                int low5;
                run_tx(64'h85E813540F0AB405, 1'b1, low5);
            end
            begin
                blk_ready = 1'b1;
                send_block(64'h0011_2233_4455_6677, 1'b0);
            end
        join
        check("c5_bit_count", 64'(out_log.size()), 64'd64);
        check("c5_stream", log_word(), 64'h85E813540F0AB405);
        @(negedge sclk);

        // 6: reset mid-block discards the partial block
        junk = 64'hFFFF_0000_AAAA_5555;
        for (int i = 0; i < 30; i++) begin
            sin_valid = 1'b1;
            sin_data  = junk[i];
            @(negedge sclk);
        end
        sin_valid = 1'b0;
        n_rst     = 1'b0;
        @(negedge sclk);
        n_rst     = 1'b1;
        check("c6_busy_after_rst", 64'(busy), 64'd0);
        blk_ready = 1'b0;
        send_block(64'hFEDC_BA98_7654_3210, 1'b0);
        check("c6_blk_valid", 64'(blk_valid), 64'd1);
        check("c6_blk_data", blk_data, 64'hFEDC_BA98_7654_3210);
        check("c6_overrun", 64'(overrun), 64'd0);
        blk_ready = 1'b1;
        @(negedge sclk);
        blk_ready = 1'b0;
        @(negedge sclk);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_des_io_sequencer
